// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared core types for the fetch stage. Provides the NOP
//               instruction word, the fetch FSM state type and the entry
//               format stored in the fetch instruction buffer.
//               When FETCH_MISALIGN_EN is defined, each entry carries an
//               extra misaligned-redirect exception flag.
//               The default datapath width comes from `XLEN (32 when the
//               macro is not supplied).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

package core_pkg;

    // Width of the PC field stored in buffer entries. Any fetch_unit
    // instance must use the same XLEN.
    localparam int unsigned CORE_XLEN = `XLEN;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [0:0] {
        BOOT  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]           inst;
        logic [CORE_XLEN-1:0]  pc;
`ifdef FETCH_MISALIGN_EN
        logic                  exc;
`endif
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous in-order FIFO of fetch_entry_t, DEPTH entries.
//               Head entry is read straight from the storage registers, so a
//               push in cycle N is visible at the head in cycle N+1.
//               A flush empties the buffer; a push in the same cycle as a
//               flush becomes the only entry afterwards.
// Ports       : clk, rst_n (async, active-low)
//               push / push_data  - write one entry
//               pop               - drop the head entry (never while empty)
//               flush             - discard all entries
//               head              - current head entry
//               count             - number of valid entries
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_wr_idx;

    // A push during flush lands in slot 0, matching the rewound pointers.
    assign w_wr_idx = flush ? '0 : r_wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= push ? PW'(1) : '0;
            r_count  <= push ? CW'(1) : '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed while count > 0.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

    a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && (r_count == CW'(DEPTH))));

    a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && !flush && (r_count == '0)));

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Generates word-aligned PCs, issues
//               reads on the instruction-memory port with a credit limit of
//               FIFO_DEPTH (buffered + outstanding), buffers in-order
//               responses and presents (inst, inst_pc) to decode over a
//               valid/ready handshake. A redirect flushes the buffer and
//               marks every still-outstanding read for discard.
// Parameters  : XLEN (datapath width), RESET_PC, FIFO_DEPTH (power of 2, >=2)
// Ports       : clk, rst_n (async, active-low)
//               imem_req/imem_addr/imem_gnt     - request channel
//               imem_rvalid/imem_rdata          - in-order response channel
//               redirect/redirect_pc            - flush and restart
//               inst_valid/inst_ready/inst/inst_pc - decode handshake
//               inst_exc_misalign               - only with FETCH_MISALIGN_EN
// Config      : FETCH_MISALIGN_EN - a misaligned redirect target yields one
//               NOP entry flagged as an exception and parks fetch until the
//               next redirect. Without it, redirect_pc[1:0] is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import core_pkg::*;
#(
    parameter int unsigned     XLEN       = `XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
`ifdef FETCH_MISALIGN_EN
    output logic            inst_exc_misalign,
`endif
    output logic [XLEN-1:0] inst_pc
);

    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] C_DEPTH = (CW + 1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] C_STEP = XLEN'(4);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;
    logic [31:0]     r_last_inst;
    logic [XLEN-1:0] r_last_pc;

    logic [CW-1:0]   w_fifo_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_empty;
    logic [CW:0]     w_credit;
    logic            w_idle;
    logic            w_req;
    logic            w_gnt_hs;
    logic            w_rsp;
    logic            w_keep;
    logic [CW-1:0]   w_out_next;
    logic [XLEN-1:0] w_target;

    assign w_target = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_EN
    logic r_idle;
    logic w_misalign;

    assign w_misalign = redirect && (redirect_pc[1:0] != 2'b00);
    assign w_idle     = r_idle;

    // Misaligned target parks fetch; an aligned redirect wakes it up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= 1'b0;
        end else if (redirect) begin
            r_idle <= w_misalign;
        end
    end
`else
    logic w_unused_low_bits;

    assign w_unused_low_bits = ^redirect_pc[1:0];
    assign w_idle            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Request side. Buffered entries and in-flight reads share the same
    // credit pool, so a response can always be pushed without a full check.
    // Since the pool only shrinks through a grant, a raised request stays
    // raised (with a stable address) until granted or withdrawn by redirect.
    // ------------------------------------------------------------------
    assign w_credit = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign w_req    = (r_state == FETCH) && !w_idle && (w_credit < C_DEPTH) && !redirect;
    assign w_gnt_hs = w_req && imem_gnt;

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;

    // ------------------------------------------------------------------
    // Response side. Stray responses (nothing outstanding) are ignored.
    // Responses are dropped while discard credits remain or when they
    // coincide with a redirect.
    // ------------------------------------------------------------------
    assign w_rsp  = imem_rvalid && (r_outstanding != '0);
    assign w_keep = w_rsp && (r_discard == '0) && !redirect;

    always_comb begin
        w_out_next = r_outstanding;
        if (w_gnt_hs) begin
            w_out_next = w_out_next + 1'b1;
        end
        if (w_rsp) begin
            w_out_next = w_out_next - 1'b1;
        end
    end

    always_comb begin
        w_push_data.inst = imem_rdata;
        w_push_data.pc   = r_resp_pc;
        w_push            = w_keep;
`ifdef FETCH_MISALIGN_EN
        w_push_data.exc  = 1'b0;
        if (w_misalign) begin
            w_push_data.inst = NOP_INST;
            w_push_data.pc   = redirect_pc;
            w_push_data.exc  = 1'b1;
            w_push           = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // FSM and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            case (r_state)
                BOOT:    r_state <= FETCH;
                FETCH:   r_state <= FETCH;
                default: r_state <= BOOT;
            endcase

            r_outstanding <= w_out_next;

            if (redirect) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                // Everything still in flight after this cycle is stale.
                r_discard  <= w_out_next;
            end else begin
                if (w_gnt_hs) begin
                    r_fetch_pc <= r_fetch_pc + C_STEP;
                end
                if (w_keep) begin
                    r_resp_pc <= r_resp_pc + C_STEP;
                end
                if (w_rsp && (r_discard != '0)) begin
                    r_discard <= r_discard - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Instruction buffer and decode interface
    // ------------------------------------------------------------------
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (redirect),
        .head      (w_head),
        .count     (w_fifo_count)
    );

    assign w_fifo_empty = (w_fifo_count == '0);
    assign inst_valid   = !w_fifo_empty;
    assign w_pop        = inst_valid && inst_ready;

    // With the buffer empty, decode keeps seeing the last consumed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_inst <= NOP_INST;
            r_last_pc   <= '0;
        end else if (w_pop) begin
            r_last_inst <= w_head.inst;
            r_last_pc   <= w_head.pc;
        end
    end

    assign inst    = w_fifo_empty ? r_last_inst : w_head.inst;
    assign inst_pc = w_fifo_empty ? r_last_pc   : w_head.pc;

`ifdef FETCH_MISALIGN_EN
    assign inst_exc_misalign = !w_fifo_empty && w_head.exc;
`endif

    a_rvalid_expected : assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && (r_outstanding == '0)));

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A memory responder with
//               random grant/latency returns a fixed hash of each address.
//               The reference model tracks the architectural fetch order:
//               every word handed to decode must be the next sequential PC
//               from the last redirect (or reset) target, carrying the word
//               the memory holds there. Directed scenarios cover boot
//               timing, back-pressure, grant stalls and redirects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;
    import core_pkg::*;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_EN
    logic        inst_exc_misalign;
`endif

    fetch_unit #(
        .XLEN       (XLEN),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_gnt          (imem_gnt),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .inst_valid        (inst_valid),
        .inst_ready        (inst_ready),
        .inst              (inst),
`ifdef FETCH_MISALIGN_EN
        .inst_exc_misalign (inst_exc_misalign),
`endif
        .inst_pc           (inst_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0013;
    endfunction

    // ---------------- environment / reference model state ----------------
    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    pend_t       pend_q[$];
    int          gnt_mode = 1;      // 0 random, 1 always, 2 never
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    bit          rand_ready = 1'b0;
    int unsigned cyc = 0;

    logic [31:0] exp_fetch, exp_pop, last_inst, last_pc, mis_pc, last_gnt_addr, last_pop_pc;
    bit          mis_pending, idle, chk_flush;
    int          gnt_cnt, pop_cnt;
    int          pop_total = 0;

    task automatic env_reset();
        pend_q.delete();
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        exp_fetch     = RST_PC;
        exp_pop       = RST_PC;
        last_inst     = NOP;
        last_pc       = '0;
        mis_pc        = '0;
        mis_pending   = 1'b0;
        idle          = 1'b0;
        chk_flush     = 1'b0;
        gnt_cnt       = 0;
        pop_cnt       = 0;
        last_gnt_addr = '0;
        last_pop_pc   = '0;
    endtask

    task automatic sample_and_model();
        logic do_pop;
        logic do_gnt;
        pend_t p;
        do_pop = inst_valid && inst_ready;
        do_gnt = imem_req && imem_gnt;

        if (chk_flush) begin
            check_eq("flush_valid", inst_valid, 1'b0);
            chk_flush = 1'b0;
        end
        if (!inst_valid) begin
            check_eq("hold_inst", inst, last_inst);
            check_eq("hold_pc", inst_pc, last_pc);
        end
        if (redirect) check_eq("redir_req", imem_req, 1'b0);
        if (idle && !redirect) check_eq("idle_req", imem_req, 1'b0);

        if (do_pop) begin
            if (!redirect) begin
                if (mis_pending) begin
                    check_eq("mis_pc", inst_pc, mis_pc);
                    check_eq("mis_inst", inst, NOP);
`ifdef FETCH_MISALIGN_EN
                    check_eq("mis_exc", inst_exc_misalign, 1'b1);
`endif
                    mis_pending = 1'b0;
                end else begin
                    check_eq("pop_pc", inst_pc, exp_pop);
                    check_eq("pop_inst", inst, mem_word(exp_pop));
`ifdef FETCH_MISALIGN_EN
                    check_eq("pop_exc", inst_exc_misalign, 1'b0);
`endif
                    exp_pop = exp_pop + 32'd4;
                end
                pop_cnt++;
                pop_total++;
                last_pop_pc = inst_pc;
            end
            last_inst = inst;
            last_pc   = inst_pc;
        end

        if (do_gnt) begin
            check_eq("gnt_addr", imem_addr, exp_fetch);
            check_eq("credit", pend_q.size() < DEPTH, 1'b1);
            p.addr = imem_addr;
            p.due  = cyc + $urandom_range(lat_min, lat_max);
            pend_q.push_back(p);
            exp_fetch     = exp_fetch + 32'd4;
            last_gnt_addr = imem_addr;
            gnt_cnt++;
        end

        if (imem_rvalid) void'(pend_q.pop_front());

        if (redirect) begin
`ifdef FETCH_MISALIGN_EN
            if (redirect_pc[1:0] != 2'b00) begin
                idle        = 1'b1;
                mis_pending = 1'b1;
                mis_pc      = redirect_pc;
            end else begin
                idle        = 1'b0;
                mis_pending = 1'b0;
                chk_flush   = 1'b1;
            end
`else
            chk_flush = 1'b1;
`endif
            exp_fetch = {redirect_pc[31:2], 2'b00};
            exp_pop   = {redirect_pc[31:2], 2'b00};
        end
    endtask

    // Memory responder + monitor: drives at the falling edge, samples 3 later.
    initial begin
        env_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                env_reset();
                continue;
            end
            cyc++;
            case (gnt_mode)
                1:       imem_gnt = 1'b1;
                2:       imem_gnt = 1'b0;
                default: imem_gnt = 1'($urandom_range(0, 1));
            endcase
            if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_q[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
            if (rand_ready) inst_ready = ($urandom_range(0, 9) < 7);
            #3;
            if (!rst_n) begin
                env_reset();
                continue;
            end
            sample_and_model();
        end
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        #1;
        redirect = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_eq("rst_req", imem_req, 1'b0);
        check_eq("rst_addr", imem_addr, RST_PC);
        check_eq("rst_valid", inst_valid, 1'b0);
        check_eq("rst_inst", inst, NOP);
        check_eq("rst_pc", inst_pc, 32'h0);
`ifdef FETCH_MISALIGN_EN
        check_eq("rst_exc", inst_exc_misalign, 1'b0);
`endif
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] exp_pc);
        int p0;
        bit seen;
        p0   = pop_cnt;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #4;
            if (pop_cnt > p0) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_seen"}, seen, 1'b1);
        check_eq({tag, "_pc"}, last_pop_pc, exp_pc);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit hit;

        // ---- 1: boot timing and in-order stream ----
        gnt_mode = 1; lat_min = 1; lat_max = 1; rand_ready = 1'b0; inst_ready = 1'b1;
        do_reset();
        #1;
        check_eq("t1_boot_req", imem_req, 1'b0);
        @(negedge clk); #2;
        check_eq("t1_first_req", imem_req, 1'b1);
        check_eq("t1_first_addr", imem_addr, RST_PC);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); #4;
            if (pop_cnt >= 4) break;
        end
        check_eq("t1_pops", pop_cnt >= 4, 1'b1);
        check_eq("t1_fourth_pc", last_pop_pc, 32'hC);

        // ---- 2: back-pressure, credit limit ----
        inst_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        #2;
        check_eq("t2_grants", gnt_cnt, 2);
        check_eq("t2_req_low", imem_req, 1'b0);
        check_eq("t2_valid", inst_valid, 1'b1);
        check_eq("t2_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #4;
            if (gnt_cnt >= 3) break;
        end
        check_eq("t2_resume", gnt_cnt >= 3, 1'b1);
        check_eq("t2_resume_addr", last_gnt_addr, 32'h8);
        check_eq("t2_pops", pop_cnt, 2);

        // ---- 3: grant withheld ----
        gnt_mode = 2;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #2;
            check_eq("t3_req_hold", imem_req, 1'b1);
            check_eq("t3_addr_hold", imem_addr, RST_PC);
        end
        gnt_mode = 1;
        @(negedge clk); #2;
        check_eq("t3_gnt_addr", imem_addr, RST_PC);
        gnt_mode = 2;
        @(negedge clk); #2;
        check_eq("t3_next_addr", imem_addr, 32'h4);
        check_eq("t3_next_req", imem_req, 1'b1);

        // ---- 4: redirect with two reads in flight ----
        gnt_mode = 1; lat_min = 6; lat_max = 6;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #4;
            if (gnt_cnt >= 2) break;
        end
        check_eq("t4_two_out", pend_q.size(), 2);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        wait_pop("t4", 32'h100);

        // ---- 5: redirect coinciding with response and pop ----
        lat_min = 1; lat_max = 1;
        do_reset();
        hit = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); #2;
            if (imem_rvalid && inst_valid && inst_ready) begin
                redirect = 1'b1; redirect_pc = 32'h300;
                hit = 1'b1;
                break;
            end
        end
        check_eq("t5_aligned", hit, 1'b1);
        @(negedge clk);
        redirect = 1'b0;
        #2;
        check_eq("t5_empty", inst_valid, 1'b0);
        wait_pop("t5", 32'h300);

`ifdef FETCH_MISALIGN_EN
        // ---- 6: misaligned redirect ----
        lat_min = 2; lat_max = 2;
        do_reset();
        repeat (4) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h102;
        @(negedge clk);
        redirect = 1'b0;
        #2;
        check_eq("t6_valid", inst_valid, 1'b1);
        check_eq("t6_exc", inst_exc_misalign, 1'b1);
        check_eq("t6_pc", inst_pc, 32'h102);
        check_eq("t6_inst", inst, NOP);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #2;
            check_eq("t6_no_req", imem_req, 1'b0);
        end
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 1'b0;
        wait_pop("t6", 32'h200);
`endif

        // ---- random traffic with a reset in the middle ----
        gnt_mode = 0; lat_min = 1; lat_max = 4; rand_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                continue;
            end
            @(negedge clk);
            redirect    = ($urandom_range(0, 99) < 3);
            redirect_pc = $urandom;
`ifdef FETCH_MISALIGN_EN
            if ($urandom_range(0, 7) != 0) redirect_pc[1:0] = 2'b00;
`endif
        end
        @(negedge clk);
        redirect = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rand_progress", pop_total > 200, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
